ir_nec_transmitter: RTL
=======================

# ir_nec_transmitter

Encodes one 8-bit address and 8-bit command into a complete NEC-format infrared frame and drives a 38 kHz-modulated IR LED output. It is the transmit-side counterpart to the IR receive path (clock divider, simplifier, parser), which decodes the same frame format into Up/Down/Left/Right. The main uses are loopback testing of the receive path and driving external IR devices from the VGA game logic.

## Interface
- CLOCKS_PER_UNIT, 28125: system clocks per NEC unit (562.5 µs at 50 MHz).
- CARRIER_HALF, 658: system clocks per carrier half-period (≈38 kHz at 50 MHz).
- Clock  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high; returns the block to IDLE.
- Start  input  1  request a frame; sampled only in IDLE.
- Address  input  8  NEC address; latched on accepted Start.
- Command  input  8  NEC command; latched on accepted Start.
- Busy  output  1  high while a frame is in progress.
- Done  output  1  one-cycle pulse after the frame completes.
- Envelope  output  1  unmodulated mark (1) / space (0).
- IR_Out  output  1  Envelope AND carrier; drives the LED.

## Operation
- Reset values: Busy=0, Done=0, Envelope=0, IR_Out=0, state IDLE, all counters 0.
- Frame content:
  - Leader: 16-unit mark, then 8-unit space.
  - 32 data bits, LSB first in this byte order: Address, ~Address, Command, ~Command.
  - Bit 0: 1-unit mark + 1-unit space. Bit 1: 1-unit mark + 3-unit space.
  - Stop: 1-unit mark.
- States: IDLE → LEADER_MARK (16 units) → LEADER_SPACE (8) → BIT_MARK (1) → BIT_SPACE (1 or 3) → back to BIT_MARK while the bit index is below 31 → STOP_MARK (1) → IDLE.
- Counters:
  - Unit tick counter: 0..CLOCKS_PER_UNIT-1.
  - Segment unit counter: up to 16.
  - Bit index: 5 bits.
- Data is held in a 32-bit shift register loaded on Start. It shifts right on entry to each BIT_SPACE; bit 0 selects the space length.
- Envelope is 1 in the *_MARK states and 0 otherwise. It is registered, not decoded combinationally.
- Carrier:
  - The divider runs only while Envelope=1. It is held at 0 with phase=1 when Envelope=0, so every mark begins with IR_Out high.
  - Phase toggles every CARRIER_HALF clocks; duty is 50%.
- Start while Busy is ignored, with no queuing. Address and Command changes during a frame have no effect.
- Reset asserted mid-frame: outputs go to 0 immediately. No Done pulse is produced, and the frame is abandoned.

## Timing
- Start is high at edge N in IDLE: at edge N the inputs are latched, and from edge N onward Busy=1 and Envelope=1.
- Frame length is always 121 units, i.e. 121·CLOCKS_PER_UNIT cycles of Busy=1. Each byte/complement pair contributes 8 ones and 8 zeros, so the count is 24 + 16·2 + 16·4 + 1.
- Busy falls at the edge ending STOP_MARK. Done is high for exactly the following cycle.
- A Start present in the Done cycle is accepted. Back-to-back frames therefore have exactly 1 idle cycle between them.
- Segment boundaries fall exactly on unit-tick wrap. No drift is permitted across the frame.

## Structure
- Shared package ir_pkg:
  - State enum ir_tx_state_t.
  - Unit-count constants LEADER_MARK_UNITS=16, LEADER_SPACE_UNITS=8, ONE_SPACE_UNITS=3, ZERO_SPACE_UNITS=1, FRAME_UNITS=121.
  - Command codes: CMD_UP=8'h18, CMD_DOWN=8'h52, CMD_LEFT=8'h08, CMD_RIGHT=8'h5A. These are shared with the parser.
- One sub-module: ir_carrier_gen (Clock, Reset, Enable, Carrier). It contains the gated divider.

## Test plan
Use CLOCKS_PER_UNIT=4 and CARRIER_HALF=1 throughout.
- Reset, then idle 20 cycles → Busy, Done, Envelope and IR_Out all stay 0.
- Start pulse with Address=8'h00, Command=CMD_UP → Busy high exactly 484 cycles. Envelope is high for the first 64 cycles, then low for 32. Decoded bit stream is 32'hE718FF00 (LSB first). Done pulses once, in the cycle after Busy falls.
- Any mark segment → IR_Out toggles every cycle starting high, and is 0 whenever Envelope=0.
- Start re-pulsed mid-frame, and Command changed mid-frame → frame unchanged, still 484 cycles, no second frame.
- Start held high continuously → frames repeat with exactly 1 idle cycle (the Done cycle) between Busy periods.
- Reset asserted at cycle 200 of a frame → all outputs 0 asynchronously, no Done. After release, Start begins a fresh full frame.

Source files
------------

// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared NEC infrared frame constants, state encoding and command codes
package ir_pkg;

  typedef enum logic [2:0] {
    TX_IDLE         = 3'd0,
    TX_LEADER_MARK  = 3'd1,
    TX_LEADER_SPACE = 3'd2,
    TX_BIT_MARK     = 3'd3,
    TX_BIT_SPACE    = 3'd4,
    TX_STOP_MARK    = 3'd5
  } ir_tx_state_t;

  localparam int LEADER_MARK_UNITS  = 16;
  localparam int LEADER_SPACE_UNITS = 8;
  localparam int ONE_SPACE_UNITS    = 3;
  localparam int ZERO_SPACE_UNITS   = 1;
  localparam int FRAME_UNITS        = 121;

  localparam logic [7:0] CMD_UP    = 8'h18;
  localparam logic [7:0] CMD_DOWN  = 8'h52;
  localparam logic [7:0] CMD_LEFT  = 8'h08;
  localparam logic [7:0] CMD_RIGHT = 8'h5A;

endpackage

// File: rtl/ir_nec_transmitter_if.sv
// rtl/ir_nec_transmitter_if.sv - frame request and IR output bundle for the NEC transmitter
interface ir_nec_transmitter_if;
  logic       start;
  logic [7:0] address;
  logic [7:0] command;
  logic       busy;
  logic       done;
  logic       envelope;
  logic       ir_out;

  modport master (
    output start, address, command,
    input  busy, done, envelope, ir_out
  );

  modport slave (
    input  start, address, command,
    output busy, done, envelope, ir_out
  );
endinterface

// File: rtl/ir_carrier_gen.sv
// rtl/ir_carrier_gen.sv - gated 50% duty carrier divider; parks at phase 1 while disabled
module ir_carrier_gen #(
  parameter int CARRIER_HALF = 658
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  output logic o_carrier
);

  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CARRIER_HALF - 1);

  logic [CW-1:0] r_count;
  logic          r_phase;

  // Parking at phase 1 guarantees every mark opens with the LED on.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_phase <= 1'b1;
    end else if (!i_enable) begin
      r_count <= '0;
      r_phase <= 1'b1;
    end else if (r_count == HALF_LAST) begin
      r_count <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_carrier = r_phase;

endmodule

// File: rtl/ir_nec_transmitter.sv
// rtl/ir_nec_transmitter.sv - NEC frame sequencer: leader, 32 data bits LSB first, stop mark
module ir_nec_transmitter
  import ir_pkg::*;
#(
  parameter int CLOCKS_PER_UNIT = 28125,
  parameter int CARRIER_HALF    = 658
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ir_nec_transmitter_if.slave   bus
);

  localparam logic [2:0] S_IDLE         = TX_IDLE;
  localparam logic [2:0] S_LEADER_MARK  = TX_LEADER_MARK;
  localparam logic [2:0] S_LEADER_SPACE = TX_LEADER_SPACE;
  localparam logic [2:0] S_BIT_MARK     = TX_BIT_MARK;
  localparam logic [2:0] S_BIT_SPACE    = TX_BIT_SPACE;
  localparam logic [2:0] S_STOP_MARK    = TX_STOP_MARK;

  localparam int TW = (CLOCKS_PER_UNIT > 1) ? $clog2(CLOCKS_PER_UNIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLOCKS_PER_UNIT - 1);

  logic [2:0]    r_state;
  logic [TW-1:0] r_tick;
  logic [4:0]    r_units;
  logic [4:0]    r_bit_idx;
  logic [31:0]   r_shreg;
  logic          r_space_one;
  logic          r_busy;
  logic          r_done;
  logic          r_env;

  logic [4:0]    w_seg_last;
  logic          w_unit_end;
  logic          w_seg_end;
  logic          w_carrier;

  always_comb begin
    w_seg_last = 5'd0;
    case (r_state)
      S_LEADER_MARK:  w_seg_last = 5'(LEADER_MARK_UNITS - 1);
      S_LEADER_SPACE: w_seg_last = 5'(LEADER_SPACE_UNITS - 1);
      S_BIT_SPACE:    w_seg_last = r_space_one ? 5'(ONE_SPACE_UNITS - 1)
                                               : 5'(ZERO_SPACE_UNITS - 1);
      default:        w_seg_last = 5'd0;
    endcase
  end

  // Segments only end on a unit-tick wrap, so the frame cannot drift.
  assign w_unit_end = (r_tick == TICK_LAST);
  assign w_seg_end  = w_unit_end && (r_units == w_seg_last);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_tick      <= '0;
      r_units     <= '0;
      r_bit_idx   <= '0;
      r_shreg     <= '0;
      r_space_one <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_env       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (bus.start) begin
          r_state   <= S_LEADER_MARK;
          r_busy    <= 1'b1;
          r_env     <= 1'b1;
          r_tick    <= '0;
          r_units   <= '0;
          r_bit_idx <= '0;
          r_shreg   <= {~bus.command, bus.command, ~bus.address, bus.address};
        end
      end else begin
        r_tick <= w_unit_end ? '0 : r_tick + 1'b1;
        if (w_unit_end) begin
          r_units <= w_seg_end ? 5'd0 : r_units + 5'd1;
        end
        if (w_seg_end) begin
          case (r_state)
            S_LEADER_MARK: begin
              r_state <= S_LEADER_SPACE;
              r_env   <= 1'b0;
            end
            S_LEADER_SPACE: begin
              r_state <= S_BIT_MARK;
              r_env   <= 1'b1;
            end
            S_BIT_MARK: begin
              r_state     <= S_BIT_SPACE;
              r_env       <= 1'b0;
              r_space_one <= r_shreg[0];
              r_shreg     <= {1'b0, r_shreg[31:1]};
            end
            S_BIT_SPACE: begin
              r_env <= 1'b1;
              if (r_bit_idx < 5'd31) begin
                r_state   <= S_BIT_MARK;
                r_bit_idx <= r_bit_idx + 5'd1;
              end else begin
                r_state <= S_STOP_MARK;
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_env   <= 1'b0;
              r_done  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  ir_carrier_gen #(
    .CARRIER_HALF (CARRIER_HALF)
  ) u_carrier (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_enable  (r_env),
    .o_carrier (w_carrier)
  );

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.envelope = r_env;
  assign bus.ir_out   = r_env & w_carrier;

endmodule
